// File: rtl/spi_flash_boot_loader_if.sv
// SPI flash pins and instruction-memory write port of the boot loader.
// The loader drives the master modport; the flash and memory sit on the slave side.
interface spi_flash_boot_loader_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMEM_AW = 10
);
    logic               miso;
    logic               mosi;
    logic               sclk;
    logic               cs_n;
    logic               wr_en;
    logic [IMEM_AW-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;

    modport master (
        input  miso,
        output mosi, sclk, cs_n, wr_en, wr_addr, wr_data
    );

    modport slave (
        output miso,
        input  mosi, sclk, cs_n, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_flash_boot_loader.sv
// Boot loader: READ (0x03) + address to an SPI flash, streams words into instruction memory.
// Optional trailing checksum word check is enabled by defining FLASH_CHECKSUM_EN.
module spi_flash_boot_loader #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       IMEM_AW    = 10,
    parameter int unsigned       MAX_WORDS  = 1024,
    parameter logic [23:0]       START_ADDR = 24'h000000,
    parameter int unsigned       SCLK_DIV   = 1,
    parameter logic [DATA_W-1:0] END_MARKER = {DATA_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    spi_flash_boot_loader_if.master bus,
    output logic [IMEM_AW:0]        word_count,
    output logic                    busy,
    output logic                    prg_mode,
    output logic                    overflow,
    output logic                    csum_err
);

    localparam int unsigned      DivW      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned      CntW      = 7;
    localparam logic [DivW-1:0]  DivLast   = DivW'(SCLK_DIV - 1);
    localparam logic [CntW-1:0]  CmdLast   = CntW'(31);
    localparam logic [CntW-1:0]  DataLast  = CntW'(DATA_W - 1);
    localparam logic [IMEM_AW:0] WordLimit = (IMEM_AW + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StWrite,
`ifdef FLASH_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [DivW-1:0]    div_q, div_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic [31:0]        cmd_q, cmd_d;
    logic [CntW-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               vld_q, vld_d;
    logic               wr_en_q, wr_en_d;
    logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [IMEM_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
`ifdef FLASH_CHECKSUM_EN
    logic               cerr_q, cerr_d;
    logic [DATA_W-1:0]  sum_q, sum_d;
`endif

    logic             running;
    logic             tick;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             start_load;
    logic [IMEM_AW:0] count_inc;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        cmd_d      = cmd_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        vld_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
`ifdef FLASH_CHECKSUM_EN
        cerr_d     = cerr_q;
        sum_d      = sum_q;
`endif
        start_load = 1'b0;
        count_inc  = count_q + 1'b1;
        running    = (state_q != StIdle) && (state_q != StDone);
        tick       = (div_q == DivLast);
        sclk_rise  = running && tick && !sclk_q;
        sclk_fall  = running && tick && sclk_q;

        if (running) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) sclk_d = ~sclk_q;
        end

        // Data sampling runs independently of the FSM so sclk never pauses for writes.
        if (sclk_rise && (state_q != StCmd)) begin
            shift_d = {shift_q[DATA_W-2:0], bus.miso};
            if (bit_q == DataLast) begin
                bit_d = '0;
                vld_d = 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: start_load = 1'b1;
            StCmd: begin
                if (sclk_fall) begin
                    cmd_d = {cmd_q[30:0], 1'b0};
                    if (bit_q == CmdLast) begin
                        bit_d   = '0;
                        state_d = StData;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (vld_q) begin
                    if (shift_q == END_MARKER) begin
`ifdef FLASH_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d   = StWrite;
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q[IMEM_AW-1:0];
                        wr_data_d = shift_q;
                    end
                end
            end
            StWrite: begin
                count_d = count_inc;
`ifdef FLASH_CHECKSUM_EN
                sum_d   = sum_q + wr_data_q;
`endif
                if (count_inc == WordLimit) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StData;
                end
            end
`ifdef FLASH_CHECKSUM_EN
            StCsum: begin
                if (vld_q) begin
                    cerr_d  = (shift_q != sum_q);
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (start) begin
                    start_load = 1'b1;
                    count_d    = '0;
                    ovf_d      = 1'b0;
`ifdef FLASH_CHECKSUM_EN
                    cerr_d     = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_load) begin
            state_d = StCmd;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            shift_d = '0;
            cmd_d   = {8'h03, START_ADDR};
`ifdef FLASH_CHECKSUM_EN
            sum_d   = '0;
`endif
        end

        // Deselecting the flash always parks the clock low.
        if (state_d == StDone) begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            div_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            cmd_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            vld_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
`ifdef FLASH_CHECKSUM_EN
            cerr_q    <= 1'b0;
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            cmd_q     <= cmd_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            vld_q     <= vld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
`ifdef FLASH_CHECKSUM_EN
            cerr_q    <= cerr_d;
            sum_q     <= sum_d;
`endif
        end
    end

    assign bus.mosi    = cmd_q[31];
    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign word_count  = count_q;
    assign busy        = running;
    assign prg_mode    = (state_q == StDone);
    assign overflow    = ovf_q;
`ifdef FLASH_CHECKSUM_EN
    assign csum_err    = cerr_q;
`else
    assign csum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Bench for spi_flash_boot_loader: two instances (32-bit/div 1/limit 4, 16-bit/div 3),
// each with a behavioural mode-0 SPI flash and a write-port scoreboard.
module tb_spi_flash_boot_loader;

    localparam logic [31:0] END0 = 32'hFFFF_FFFF;
`ifdef FLASH_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic       rst0, rst1, start0, start1;
    logic [4:0] wc0;
    logic [6:0] wc1;
    logic       busy0, prg0, ovf0, cerr0;
    logic       busy1, prg1, ovf1, cerr1;

    spi_flash_boot_loader_if #(.DATA_W(32), .IMEM_AW(4)) if0 ();
    spi_flash_boot_loader_if #(.DATA_W(16), .IMEM_AW(6)) if1 ();

    spi_flash_boot_loader #(
        .DATA_W(32), .IMEM_AW(4), .MAX_WORDS(4), .START_ADDR(24'h000000), .SCLK_DIV(1)
    ) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .bus(if0), .word_count(wc0),
        .busy(busy0), .prg_mode(prg0), .overflow(ovf0), .csum_err(cerr0)
    );

    spi_flash_boot_loader #(
        .DATA_W(16), .IMEM_AW(6), .MAX_WORDS(64), .START_ADDR(24'h000100), .SCLK_DIV(3)
    ) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .bus(if1), .word_count(wc1),
        .busy(busy1), .prg_mode(prg1), .overflow(ovf1), .csum_err(cerr1)
    );

    // Flash 0: 32-bit words, shifts data out on sclk falling edges after 32 command bits
    logic [31:0] f0_words [16];
    logic [31:0] f0_cmd;
    int          f0_rise, f0_b;
    logic        f0_miso = 1'b0;
    assign if0.miso = f0_miso;
    always @(negedge if0.cs_n) f0_rise = 0;
    always @(posedge if0.sclk) if (!if0.cs_n) begin
        if (f0_rise < 32) f0_cmd = {f0_cmd[30:0], if0.mosi};
        f0_rise = f0_rise + 1;
    end
    always @(negedge if0.sclk) if (!if0.cs_n && f0_rise >= 32) begin
        f0_b    = f0_rise - 32;
        f0_miso = f0_words[(f0_b / 32) % 16][31 - (f0_b % 32)];
    end

    logic [15:0] f1_words [16];
    logic [31:0] f1_cmd;
    int          f1_rise, f1_b;
    logic        f1_miso = 1'b0;
    assign if1.miso = f1_miso;
    always @(negedge if1.cs_n) f1_rise = 0;
    always @(posedge if1.sclk) if (!if1.cs_n) begin
        if (f1_rise < 32) f1_cmd = {f1_cmd[30:0], if1.mosi};
        f1_rise = f1_rise + 1;
    end
    always @(negedge if1.sclk) if (!if1.cs_n && f1_rise >= 32) begin
        f1_b    = f1_rise - 32;
        f1_miso = f1_words[(f1_b / 16) % 16][15 - (f1_b % 16)];
    end

    // Scoreboards: expected {addr, data} pushed when the flash image is loaded
    logic [35:0] exp0 [$];
    logic [21:0] exp1 [$];
    logic [35:0] e0;
    logic [21:0] e1;
    logic        wr0_prev = 1'b0;
    int          wr1_times [$];

    always @(negedge clk) begin
        if (if0.wr_en) begin
            total++;
            if (exp0.size() == 0) begin
                bad++;
                $display("FAIL wr0_unexpected: got addr=%0d data=%h, required no write",
                         if0.wr_addr, if0.wr_data);
            end else begin
                e0 = exp0.pop_front();
                if ({if0.wr_addr, if0.wr_data} !== e0) begin
                    bad++;
                    $display("FAIL wr0_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             if0.wr_addr, if0.wr_data, e0[35:32], e0[31:0]);
                end
            end
            total++;
            if (wr0_prev) begin
                bad++;
                $display("FAIL wr0_spacing: got wr_en on consecutive clks, required gap");
            end
        end
        wr0_prev = if0.wr_en;
    end

    always @(negedge clk) begin
        if (if1.wr_en) begin
            wr1_times.push_back(cyc);
            total++;
            if (exp1.size() == 0) begin
                bad++;
                $display("FAIL wr1_unexpected: got addr=%0d data=%h, required no write",
                         if1.wr_addr, if1.wr_data);
            end else begin
                e1 = exp1.pop_front();
                if ({if1.wr_addr, if1.wr_data} !== e1) begin
                    bad++;
                    $display("FAIL wr1_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             if1.wr_addr, if1.wr_data, e1[21:16], e1[15:0]);
                end
            end
        end
    end

    // Loads flash 0 and queues the writes the loader should make (limit 4 words).
    task automatic fill0(input logic [31:0] w [6], input int n, input bit add_sum);
        logic [31:0] sum;
        int          cnt;
        bit          ended;
        sum   = '0;
        cnt   = 0;
        ended = 1'b0;
        for (int i = 0; i < 16; i++) f0_words[i] = END0;
        for (int i = 0; i < n; i++) begin
            f0_words[i] = w[i];
            if (!ended) begin
                if (w[i] == END0) begin
                    ended = 1'b1;
                end else begin
                    if (cnt < 4) exp0.push_back({cnt[3:0], w[i]});
                    sum = sum + w[i];
                    cnt++;
                end
            end
        end
        if (add_sum) f0_words[n] = sum;
    endtask

    task automatic pulse_start0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({if0.cs_n, if0.sclk, if0.mosi, if0.wr_en, busy0, prg0, ovf0, cerr0} !== 8'b1000_0000)
        begin
            bad++;
            $display("FAIL reset0_ctrl: got %b, required 10000000",
                     {if0.cs_n, if0.sclk, if0.mosi, if0.wr_en, busy0, prg0, ovf0, cerr0});
        end
        total++;
        if ({if0.wr_addr, if0.wr_data, wc0} !== 41'd0) begin
            bad++;
            $display("FAIL reset0_bus: got addr=%0d data=%h wc=%0d, required 0",
                     if0.wr_addr, if0.wr_data, wc0);
        end
        total++;
        if ({if1.cs_n, if1.sclk, if1.mosi, if1.wr_en, busy1, prg1, ovf1, cerr1, wc1} !==
            {8'b1000_0000, 7'd0}) begin
            bad++;
            $display("FAIL reset1: got %b wc=%0d, required 10000000 wc=0",
                     {if1.cs_n, if1.sclk, if1.mosi, if1.wr_en, busy1, prg1, ovf1, cerr1}, wc1);
        end
    endtask

    task automatic test_boot_load();
        fill0('{32'h1122_3344, 32'hA5A5_A5A5, END0, 32'h0, 32'h0, 32'h0}, 3, 1'b1);
        @(negedge clk) rst0 = 1'b1;
        @(negedge clk);
        total++;
        if ({busy0, if0.cs_n, prg0} !== 3'b100) begin
            bad++;
            $display("FAIL boot_autostart: got busy,cs_n,prg=%b, required 100",
                     {busy0, if0.cs_n, prg0});
        end
        for (int i = 0; i < 3000 && prg0 !== 1'b1; i++) @(negedge clk);
        total++;
        if (prg0 !== 1'b1) begin
            bad++;
            $display("FAIL boot_done: got prg_mode=%b, required 1", prg0);
        end
        total++;
        if (wc0 !== 5'd2 || exp0.size() != 0) begin
            bad++;
            $display("FAIL boot_count: got wc=%0d pending=%0d, required wc=2 pending=0",
                     wc0, exp0.size());
        end
        total++;
        if ({if0.cs_n, if0.sclk, busy0, ovf0} !== 4'b1000) begin
            bad++;
            $display("FAIL boot_idle_pins: got cs_n,sclk,busy,ovf=%b, required 1000",
                     {if0.cs_n, if0.sclk, busy0, ovf0});
        end
        total++;
        if (f0_cmd !== 32'h0300_0000) begin
            bad++;
            $display("FAIL boot_cmd: got %h, required 03000000", f0_cmd);
        end
    endtask

    task automatic test_overflow();
        fill0('{32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404, 32'h0000_0505,
                32'h0000_0606}, 6, 1'b0);
        pulse_start0();
        total++;
        if ({prg0, busy0, wc0} !== {2'b01, 5'd0}) begin
            bad++;
            $display("FAIL ovf_restart: got prg,busy=%b wc=%0d, required 01 wc=0",
                     {prg0, busy0}, wc0);
        end
        for (int i = 0; i < 3000 && prg0 !== 1'b1; i++) @(negedge clk);
        total++;
        if ({prg0, ovf0, cerr0} !== 3'b110 || wc0 !== 5'd4 || exp0.size() != 0) begin
            bad++;
            $display("FAIL ovf_end: got prg,ovf,cerr=%b wc=%0d pending=%0d, required 110 wc=4 0",
                     {prg0, ovf0, cerr0}, wc0, exp0.size());
        end
    endtask

    task automatic test_start_in_done_and_busy();
        fill0('{32'h1122_3344, 32'hA5A5_A5A5, END0, 32'h0, 32'h0, 32'h0}, 3, 1'b1);
        pulse_start0();
        total++;
        if ({ovf0, prg0, wc0} !== 7'd0) begin
            bad++;
            $display("FAIL start_clears: got ovf,prg=%b wc=%0d, required 00 wc=0",
                     {ovf0, prg0}, wc0);
        end
        for (int i = 0; i < 500 && f0_rise < 50; i++) @(negedge clk);
        pulse_start0();
        for (int i = 0; i < 3000 && prg0 !== 1'b1; i++) @(negedge clk);
        total++;
        if (prg0 !== 1'b1 || wc0 !== 5'd2 || exp0.size() != 0 || ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL start_busy_ignored: got prg=%b wc=%0d pending=%0d ovf=%b, %s",
                     prg0, wc0, exp0.size(), ovf0, "required prg=1 wc=2 pending=0 ovf=0");
        end
    endtask

    task automatic test_reset_mid_load();
        fill0('{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, END0, 32'h0, 32'h0}, 4, 1'b1);
        pulse_start0();
        for (int i = 0; i < 2000 && f0_rise < 113; i++) @(negedge clk);
        total++;
        if (f0_rise < 113) begin
            bad++;
            $display("FAIL midrst_reach: got %0d sclk rises, required 113", f0_rise);
        end
        #2 rst0 = 1'b0;
        #1;
        total++;
        if ({if0.cs_n, if0.sclk, if0.mosi, if0.wr_en, busy0, prg0, ovf0, cerr0} !== 8'b1000_0000
            || {if0.wr_addr, if0.wr_data, wc0} !== 41'd0) begin
            bad++;
            $display("FAIL midrst_outs: got %b addr=%0d data=%h wc=%0d, required 10000000 0 0 0",
                     {if0.cs_n, if0.sclk, if0.mosi, if0.wr_en, busy0, prg0, ovf0, cerr0},
                     if0.wr_addr, if0.wr_data, wc0);
        end
        exp0.delete();
        fill0('{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, END0, 32'h0, 32'h0}, 4, 1'b1);
        @(negedge clk) rst0 = 1'b1;
        for (int i = 0; i < 3000 && prg0 !== 1'b1; i++) @(negedge clk);
        total++;
        if (prg0 !== 1'b1 || wc0 !== 5'd3 || ovf0 !== 1'b0 || exp0.size() != 0) begin
            bad++;
            $display("FAIL midrst_reload: got prg=%b wc=%0d ovf=%b pending=%0d, %s",
                     prg0, wc0, ovf0, exp0.size(), "required prg=1 wc=3 ovf=0 pending=0");
        end
    endtask

    task automatic test_checksum();
        logic exp_err;
        for (int k = 0; k < 2; k++) begin
            fill0('{32'd1, 32'd2, END0, (k == 0) ? 32'd3 : 32'd4, 32'h0, 32'h0}, 4, 1'b0);
            exp_err = CSUM_ON && (k == 1);
            pulse_start0();
            for (int i = 0; i < 3000 && prg0 !== 1'b1; i++) @(negedge clk);
            total++;
            if (prg0 !== 1'b1 || cerr0 !== exp_err || wc0 !== 5'd2) begin
                bad++;
                $display("FAIL csum_%0d: got prg=%b csum_err=%b wc=%0d, required 1 %b 2",
                         k, prg0, cerr0, wc0, exp_err);
            end
        end
    endtask

    task automatic test_div3_16bit();
        int   r0, r1, gap;
        logic prev;
        r0   = -1;
        r1   = -1;
        prev = 1'b0;
        for (int i = 0; i < 16; i++) f1_words[i] = 16'hFFFF;
        f1_words[0] = 16'hBEEF;
        f1_words[1] = 16'h1234;
        f1_words[3] = 16'hD123;
        exp1.push_back({6'd0, 16'hBEEF});
        exp1.push_back({6'd1, 16'h1234});
        @(negedge clk) rst1 = 1'b1;
        for (int i = 0; i < 200 && r1 < 0; i++) begin
            @(negedge clk);
            if (if1.sclk && !prev) begin
                if (r0 < 0) r0 = i;
                else r1 = i;
            end
            prev = if1.sclk;
        end
        total++;
        if (r1 - r0 != 6 || r0 < 0) begin
            bad++;
            $display("FAIL div3_period: got %0d clks, required 6", r1 - r0);
        end
        for (int i = 0; i < 3000 && prg1 !== 1'b1; i++) @(negedge clk);
        total++;
        if (prg1 !== 1'b1 || wc1 !== 7'd2 || exp1.size() != 0 || cerr1 !== 1'b0) begin
            bad++;
            $display("FAIL div3_done: got prg=%b wc=%0d pending=%0d cerr=%b, %s",
                     prg1, wc1, exp1.size(), cerr1, "required prg=1 wc=2 pending=0 cerr=0");
        end
        gap = (wr1_times.size() == 2) ? wr1_times[1] - wr1_times[0] : -1;
        total++;
        if (gap != 96) begin
            bad++;
            $display("FAIL div3_spacing: got %0d clks between writes, required 96", gap);
        end
        total++;
        if (f1_cmd !== 32'h0300_0100) begin
            bad++;
            $display("FAIL div3_cmd: got %h, required 03000100", f1_cmd);
        end
    endtask

    initial begin
        rst0   = 1'b0;
        rst1   = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        f0_cmd = '0;
        f1_cmd = '0;
        for (int i = 0; i < 16; i++) begin
            f0_words[i] = END0;
            f1_words[i] = 16'hFFFF;
        end
        test_reset();
        test_boot_load();
        test_overflow();
        test_start_in_done_and_busy();
        test_reset_mid_load();
        test_checksum();
        test_div3_16bit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
